// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline-stage register.
package pipe_pkg;

    // Occupancy of the stage: main register and skid register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // main empty, skid empty
        ST_BUSY  = 2'd1,   // main full,  skid empty
        ST_FULL  = 2'd2    // main full,  skid full
    } pipe_state_t;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CTRL_W = 16;
    localparam int PIPE_CNT_W  = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
// Counts once per clock while inc is high and sticks at all-ones.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    // Increment until all-ones, then hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// in_ready, out_valid, out_data and out_ctrl all come straight from flops,
// so no combinational path exists from either input side to the outputs.
// out_ctrl is forced to zero whenever the stage holds no valid beat.
// Optional build macro PIPE_REG_PERF_EN adds stall/bubble cycle counters.
module pipe_reg_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
`ifdef PIPE_REG_PERF_EN
    ,
    parameter int CNT_W  = PIPE_CNT_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_REG_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    pipe_state_t       state_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] main_data_reg;
    logic [CTRL_W-1:0] main_ctrl_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic [CTRL_W-1:0] skid_ctrl_reg;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = out_valid_reg & out_ready;

    // Occupancy FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            main_data_reg <= '0;
            main_ctrl_reg <= '0;
            skid_data_reg <= '0;
            skid_ctrl_reg <= '0;
        end else if (flush) begin
            // Bubble: both entries and any beat accepted this cycle are dropped.
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            main_data_reg <= '0;
            main_ctrl_reg <= '0;
            skid_data_reg <= '0;
            skid_ctrl_reg <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data_reg <= in_data;
                        main_ctrl_reg <= in_ctrl;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_data_reg <= in_data;
                        main_ctrl_reg <= in_ctrl;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat in the skid.
                        skid_data_reg <= in_data;
                        skid_ctrl_reg <= in_ctrl;
                        in_ready_reg  <= 1'b0;
                        state_reg     <= ST_FULL;
                    end else if (out_fire) begin
                        // Drained: data is left as-is, control is scrubbed.
                        main_ctrl_reg <= '0;
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_data_reg <= skid_data_reg;
                        main_ctrl_reg <= skid_ctrl_reg;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_BUSY;
                    end
                end
                default: begin
                    state_reg     <= ST_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    main_ctrl_reg <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = main_data_reg;
    assign out_ctrl  = main_ctrl_reg;

`ifdef PIPE_REG_PERF_EN
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = out_valid_reg & ~out_ready;
    assign cnt_inc[1] = ~out_valid_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            pipe_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (cnt_inc[gi]),
                .cnt (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt  = cnt_val[0];
    assign bubble_cnt = cnt_val[1];
`endif

`ifndef SYNTHESIS
    // Upstream must hold its payload while a beat is offered but refused.
    logic              hold_chk_reg;
    logic [DATA_W-1:0] hold_data_reg;
    logic [CTRL_W-1:0] hold_ctrl_reg;

    // Capture the payload whenever it was offered and refused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_chk_reg  <= 1'b0;
            hold_data_reg <= '0;
            hold_ctrl_reg <= '0;
        end else begin
            hold_chk_reg  <= in_valid & ~in_ready_reg;
            hold_data_reg <= in_data;
            hold_ctrl_reg <= in_ctrl;
        end
    end

    // Compare the current payload to the one refused last cycle.
    always @(posedge clk) begin
        if (rst && hold_chk_reg) begin
            assert ((in_data == hold_data_reg) && (in_ctrl == hold_ctrl_reg));
        end
    end
`endif

endmodule
